// File: rtl/decomm_pkg.sv
// Shared types, reset map and code decode for the decommutator.
// Used by decommutator and decomm_map_reg.
package decomm_pkg;

   typedef logic [2:0] code_t;
   typedef code_t [2:0] map_t;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   localparam int    NUM_CHAN  = 3;
   localparam int    NUM_LINES = 8;

   localparam code_t RST_CODE_CH0 = 3'b000;
   localparam code_t RST_CODE_CH1 = 3'b100;
   localparam code_t RST_CODE_CH2 = 3'b010;
   localparam map_t  RST_MAP      = {RST_CODE_CH2, RST_CODE_CH1, RST_CODE_CH0};

   // Code bits are weighted in reverse: {c2,c1,c0} selects line c0*4 + c1*2 + c2.
   function automatic logic [2:0] code_to_line(input code_t code);
      return {code[0], code[1], code[2]};
   endfunction

endpackage

// File: rtl/decomm_map_reg.sv
// Active/shadow channel map storage: writes land in the shadow copy,
// commit copies the whole shadow map into the active map in one edge.
module decomm_map_reg
   import decomm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [1:0] wr_chan,
   input  code_t      wr_code,
   input  logic       commit,
   output map_t       active_map,
   output map_t       shadow_map
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_map <= RST_MAP;
         shadow_map <= RST_MAP;
      end else begin
         // Channel index 3 matches no entry, so such writes fall through harmlessly.
         for (int i = 0; i < NUM_CHAN; i++) begin
            if (wr_en && (wr_chan == 2'(i))) begin
               shadow_map[i] <= wr_code;
            end
         end
         if (commit) begin
            active_map <= shadow_map;
         end
      end
   end

endmodule

// File: rtl/decommutator.sv
// Three-channel bit decommutator with frame-aligned map commit.
// Optional sticky collision flag enabled by defining DECOMM_COLLISION_FLAG_EN.
module decommutator
   import decomm_pkg::*;
#(
   parameter int FRAME_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] in_data,
   input  logic       in_valid,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [1:0] cfg_chan,
   input  logic [2:0] cfg_code,
   input  logic       cfg_commit,
   output logic [7:0] outputs,
   output logic [7:0] out_strobe,
   output logic       frame_start,
   output logic       commit_pending,
   output state_t     fsm_state
`ifdef DECOMM_COLLISION_FLAG_EN
   ,
   output logic       collision
`endif
);

   // Config handshake: a write transfers on any edge where cfg_valid and
   // cfg_ready are both high; cfg_ready drops for the whole commit-pending window.

   localparam int             CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_LEN - 1);

   state_t          state;
   state_t          state_nxt;
   logic            do_commit;
   logic            last_sample;
   logic            wr_en;
   logic [CW-1:0]   sample_cnt;
   map_t            active_map;
   map_t            shadow_map;
   logic [7:0]      route_mask;
   logic [7:0]      route_bits;
   logic [2:0]      line_idx;

   assign commit_pending = (state == ST_PENDING);
   assign cfg_ready      = ~commit_pending;
   assign wr_en          = cfg_valid & cfg_ready;
   assign fsm_state      = state;
   assign last_sample    = in_valid && (sample_cnt == LAST_IDX);

   decomm_map_reg u_map (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_chan    (cfg_chan),
      .wr_code    (cfg_code),
      .commit     (do_commit),
      .active_map (active_map),
      .shadow_map (shadow_map)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      do_commit = 1'b0;
      case (state)
         ST_RUN: begin
            if (cfg_commit) begin
               state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // The last sample of the frame still routes with the old map.
            if (last_sample) begin
               state_nxt = ST_RUN;
               do_commit = 1'b1;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Walk channels high to low so the lowest-index channel owns a shared line.
   always_comb begin
      route_mask = '0;
      route_bits = '0;
      line_idx   = '0;
      for (int ch = NUM_CHAN - 1; ch >= 0; ch--) begin
         line_idx             = code_to_line(active_map[ch]);
         route_mask[line_idx] = 1'b1;
         route_bits[line_idx] = in_data[ch];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outputs     <= '0;
         out_strobe  <= '0;
         frame_start <= 1'b0;
         sample_cnt  <= '0;
      end else if (in_valid) begin
         outputs     <= (outputs & ~route_mask) | (route_bits & route_mask);
         out_strobe  <= route_mask;
         frame_start <= (sample_cnt == '0);
         sample_cnt  <= (sample_cnt == LAST_IDX) ? '0 : sample_cnt + 1'b1;
      end else begin
         out_strobe  <= '0;
         frame_start <= 1'b0;
      end
   end

`ifdef DECOMM_COLLISION_FLAG_EN
   logic [2:0] line0;
   logic [2:0] line1;
   logic [2:0] line2;
   logic       multi_hit;

   assign line0     = code_to_line(active_map[0]);
   assign line1     = code_to_line(active_map[1]);
   assign line2     = code_to_line(active_map[2]);
   assign multi_hit = (line0 == line1) || (line0 == line2) || (line1 == line2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         collision <= 1'b0;
      end else if (in_valid && multi_hit) begin
         collision <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_decommutator.sv
// Bench for decommutator: two instances (FRAME_LEN 8 and 1) share one stimulus
// stream and are checked every cycle against a behavioural model plus literals.
module tb_decommutator;
   import decomm_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [1:0] cfg_chan = '0;
   logic [2:0] cfg_code = '0;
   logic       cfg_commit = 1'b0;

   logic       cfg_ready_d[2];
   logic [7:0] outputs_d[2];
   logic [7:0] out_strobe_d[2];
   logic       frame_start_d[2];
   logic       commit_pending_d[2];
   state_t     fsm_state_d[2];
`ifdef DECOMM_COLLISION_FLAG_EN
   logic       collision_d[2];
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decommutator #(.FRAME_LEN(8)) dut8 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_d[0]), .cfg_chan(cfg_chan),
      .cfg_code(cfg_code), .cfg_commit(cfg_commit), .outputs(outputs_d[0]),
      .out_strobe(out_strobe_d[0]), .frame_start(frame_start_d[0]),
      .commit_pending(commit_pending_d[0]), .fsm_state(fsm_state_d[0])
`ifdef DECOMM_COLLISION_FLAG_EN
      , .collision(collision_d[0])
`endif
   );

   decommutator #(.FRAME_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_d[1]), .cfg_chan(cfg_chan),
      .cfg_code(cfg_code), .cfg_commit(cfg_commit), .outputs(outputs_d[1]),
      .out_strobe(out_strobe_d[1]), .frame_start(frame_start_d[1]),
      .commit_pending(commit_pending_d[1]), .fsm_state(fsm_state_d[1])
`ifdef DECOMM_COLLISION_FLAG_EN
      , .collision(collision_d[1])
`endif
   );

   // ---------------- behavioural model ----------------
   int         fl[2] = '{8, 1};
   logic [2:0] m_act[2][3];
   logic [2:0] m_sh[2][3];
   bit         m_pend[2];
   int         m_cnt[2];
   logic [7:0] m_out[2];
   logic [7:0] m_stb[2];
   bit         m_fs[2];
   bit         m_coll[2];

   function automatic int line_of(input logic [2:0] c);
      return int'(c[0]) * 4 + int'(c[1]) * 2 + int'(c[2]);
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_act[u] = '{3'b000, 3'b100, 3'b010};
         m_sh[u]  = '{3'b000, 3'b100, 3'b010};
         m_pend[u] = 0; m_cnt[u] = 0; m_out[u] = '0; m_stb[u] = '0;
         m_fs[u] = 0; m_coll[u] = 0;
      end
   endtask

   task automatic model_step(input int u);
      bit         old_pend = m_pend[u];
      bit         do_cm = 0;
      logic [7:0] hit = '0;
      m_stb[u] = '0;
      m_fs[u]  = 0;
      if (in_valid) begin
         for (int ch = 0; ch < 3; ch++) begin
            int ln = line_of(m_act[u][ch]);
            if (hit[ln]) m_coll[u] = 1;
            else begin
               hit[ln] = 1'b1;
               m_out[u][ln] = in_data[ch];
            end
         end
         m_stb[u] = hit;
         m_fs[u]  = (m_cnt[u] == 0);
         do_cm    = old_pend && (m_cnt[u] == fl[u] - 1);
         m_cnt[u] = (m_cnt[u] + 1) % fl[u];
      end
      if (!old_pend && cfg_valid && cfg_chan != 2'd3) m_sh[u][cfg_chan] = cfg_code;
      if (do_cm) for (int ch = 0; ch < 3; ch++) m_act[u][ch] = m_sh[u][ch];
      m_pend[u] = old_pend ? !do_cm : cfg_commit;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else for (int u = 0; u < 2; u++) model_step(u);
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d outputs", u), 32'(outputs_d[u]), 32'(m_out[u]));
            check($sformatf("u%0d out_strobe", u), 32'(out_strobe_d[u]), 32'(m_stb[u]));
            check($sformatf("u%0d frame_start", u), 32'(frame_start_d[u]), 32'(m_fs[u]));
            check($sformatf("u%0d commit_pending", u), 32'(commit_pending_d[u]), 32'(m_pend[u]));
            check($sformatf("u%0d cfg_ready", u), 32'(cfg_ready_d[u]), 32'(!m_pend[u]));
            check($sformatf("u%0d fsm_state", u), 32'(fsm_state_d[u]),
                  32'(m_pend[u] ? ST_PENDING : ST_RUN));
`ifdef DECOMM_COLLISION_FLAG_EN
            check($sformatf("u%0d collision", u), 32'(collision_d[u]), 32'(m_coll[u]));
`endif
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [2:0] d, input logic cv,
                        input logic [1:0] ch, input logic [2:0] code, input logic cm);
      in_valid = v; in_data = d; cfg_valid = cv; cfg_chan = ch; cfg_code = code;
      cfg_commit = cm;
      @(negedge clk);
      in_valid = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
   endtask

   task automatic sample(input logic [2:0] d);
      drive(1'b1, d, 1'b0, 2'd0, 3'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // {in_valid, in_data, cfg_valid, cfg_chan, cfg_code, cfg_commit}
   logic [10:0] vec_tab[12];

   initial begin
      vec_tab = '{
         {1'b1, 3'b110, 1'b1, 2'd3, 3'b111, 1'b0},
         {1'b1, 3'b011, 1'b1, 2'd1, 3'b110, 1'b1},
         {1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0},
         {1'b1, 3'b101, 1'b1, 2'd0, 3'b011, 1'b1},
         {1'b1, 3'b010, 1'b0, 2'd0, 3'b000, 1'b0},
         {1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 1'b0},
         {1'b0, 3'b111, 1'b1, 2'd2, 3'b001, 1'b0},
         {1'b1, 3'b001, 1'b0, 2'd0, 3'b000, 1'b0},
         {1'b1, 3'b100, 1'b0, 2'd0, 3'b000, 1'b1},
         {1'b1, 3'b011, 1'b0, 2'd0, 3'b000, 1'b0},
         {1'b1, 3'b110, 1'b0, 2'd0, 3'b000, 1'b0},
         {1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0}
      };

      // Reset state
      repeat (3) @(negedge clk);
      check("rst outputs", 32'(outputs_d[0]), 32'h00);
      check("rst strobe", 32'(out_strobe_d[0]), 32'h00);
      check("rst pending", 32'(commit_pending_d[0]), 32'd0);
      check("rst cfg_ready", 32'(cfg_ready_d[0]), 32'd1);
      rst = 1'b0;

      // First sample after reset
      sample(3'b101);
      check("first outputs", 32'(outputs_d[0]), 32'(8'b0000_0101));
      check("first strobe", 32'(out_strobe_d[0]), 32'(8'b0000_0111));
      check("first frame_start", 32'(frame_start_d[0]), 32'd1);

      // Write chan2 -> line 7, commit at sample 3
      drive(1'b1, 3'b000, 1'b1, 2'd2, 3'b111, 1'b0);
      sample(3'b111);
      drive(1'b1, 3'b100, 1'b0, 2'd0, 3'd0, 1'b1);
      check("commit s3 outputs", 32'(outputs_d[0]), 32'(8'b0000_0100));
      check("commit s3 pending", 32'(commit_pending_d[0]), 32'd1);
      check("commit s3 cfg_ready", 32'(cfg_ready_d[0]), 32'd0);
      sample(3'b100);
      check("fl1 old-map strobe", 32'(out_strobe_d[1]), 32'(8'b0000_0111));
      check("fl1 switched", 32'(commit_pending_d[1]), 32'd0);
      check("fl8 still pending", 32'(commit_pending_d[0]), 32'd1);
      // This write must be refused by the FRAME_LEN=8 instance (shadow locked)
      drive(1'b1, 3'b100, 1'b1, 2'd0, 3'b111, 1'b0);
      check("fl1 new-map strobe", 32'(out_strobe_d[1]), 32'(8'b1000_0011));
      check("fl1 frame_start", 32'(frame_start_d[1]), 32'd1);
      sample(3'b100);
      sample(3'b100);
      check("s7 old-map strobe", 32'(out_strobe_d[0]), 32'(8'b0000_0111));
      check("s7 pending cleared", 32'(commit_pending_d[0]), 32'd0);
      sample(3'b100);
      check("new frame strobe", 32'(out_strobe_d[0]), 32'(8'b1000_0011));
      check("new frame outputs", 32'(outputs_d[0]), 32'(8'b1000_0100));
      check("new frame start", 32'(frame_start_d[0]), 32'd1);

      // Collision map via write+commit in the same cycle
      do_reset();
      drive(1'b0, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0);
      drive(1'b0, 3'b000, 1'b1, 2'd1, 3'b001, 1'b1);
      repeat (5) drive(1'b0, 3'b000, 1'b0, 2'd0, 3'd0, 1'b0);
      check("idle pending u0", 32'(commit_pending_d[0]), 32'd1);
      check("idle pending u1", 32'(commit_pending_d[1]), 32'd1);
      for (int i = 0; i < 8; i++) begin
         sample(3'b010);
         check($sformatf("old map s%0d", i), 32'(out_strobe_d[0]), 32'(8'b0000_0111));
         check($sformatf("fl1 fs s%0d", i), 32'(frame_start_d[1]), 32'd1);
      end
      check("after 8 outputs", 32'(outputs_d[0]), 32'(8'b0000_0010));
      sample(3'b010);
      check("s8 strobe", 32'(out_strobe_d[0]), 32'(8'b0001_0100));
      check("s8 chan0 wins", 32'(outputs_d[0]), 32'(8'b0000_0010));
`ifdef DECOMM_COLLISION_FLAG_EN
      check("collision set", 32'(collision_d[0]), 32'd1);
`endif
      sample(3'b001);
      check("s9 outputs", 32'(outputs_d[0]), 32'(8'b0001_0010));

      // Reset while pending
      drive(1'b0, 3'b000, 1'b0, 2'd0, 3'd0, 1'b1);
      sample(3'b011);
      sample(3'b011);
      #2 rst = 1'b1;
      #1;
      check("async rst pending u0", 32'(commit_pending_d[0]), 32'd0);
      check("async rst pending u1", 32'(commit_pending_d[1]), 32'd0);
      check("async rst cfg_ready", 32'(cfg_ready_d[0]), 32'd1);
      check("async rst outputs", 32'(outputs_d[0]), 32'h00);
      @(negedge clk);
      rst = 1'b0;
      sample(3'b111);
      check("post-rst outputs", 32'(outputs_d[0]), 32'(8'b0000_0111));
      check("post-rst strobe", 32'(out_strobe_d[0]), 32'(8'b0000_0111));

      // Mixed directed vectors, checked by the model only
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 12; i++) begin
            logic [10:0] v;
            v = vec_tab[i];
            drive(v[10], v[9:7], v[6], v[5:4], v[3:1], v[0]);
         end
      end
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/decommutator.md
DECOMMUTATOR -- requirements
Module: decommutator

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: samples per frame, legal range 1..256.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_data, input, 3 bits: one bit per input channel 0..2.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is sampled this cycle.
REQ-006 SHALL have port cfg_valid, input, 1 bit: config write request.
REQ-007 SHALL have port cfg_ready, output, 1 bit: config write can be accepted.
REQ-008 SHALL have port cfg_chan, input, 2 bits: channel index to program.
REQ-009 SHALL have port cfg_code, input, 3 bits: destination code for that channel.
REQ-010 SHALL have port cfg_commit, input, 1 bit: request to apply the shadow map.
REQ-011 SHALL have port outputs, output, 8 bits: held destination lines.
REQ-012 SHALL have port out_strobe, output, 8 bits: per-line update pulse.
REQ-013 SHALL have port frame_start, output, 1 bit: the current update is sample 0 of a frame.
REQ-014 SHALL have port commit_pending, output, 1 bit: a commit is armed.

Function
REQ-015 SHALL decode a destination code {c2,c1,c0} to line index c0*4+c1*2+c2, so 3'b100 selects line 1 and 3'b001 selects line 4.
REQ-016 SHALL keep a 3-entry active map, which is used for routing, and a 3-entry shadow map, which receives writes.
REQ-017 SHALL accept a config write when cfg_valid=1 and cfg_ready=1, writing cfg_code into shadow[cfg_chan]; cfg_chan=3 SHALL be accepted with no effect.
REQ-018 SHALL drive cfg_ready=0 whenever commit_pending=1 (shadow locked) and cfg_ready=1 otherwise.
REQ-019 SHALL route on a cycle with in_valid=1; at the next edge, for every line k targeted by at least one channel, outputs[k] SHALL take the in_data bit of the lowest-index channel mapped to k (1-cycle latency).
REQ-020 SHALL hold untargeted lines at their previous value and SHALL hold all lines when in_valid=0.
REQ-021 SHALL pulse out_strobe[k] for exactly 1 cycle, aligned with the outputs update, for every targeted line.
REQ-022 SHALL maintain a sample counter 0..FRAME_LEN-1 that increments per accepted sample and wraps to 0; frame_start SHALL pulse with out_strobe when the routed sample had index 0.
REQ-023 SHALL implement a two-state FSM, RUN and PENDING:
- RUN to PENDING on cfg_commit=1.
- PENDING to RUN on the sample with counter=FRAME_LEN-1; that sample routes with the old map and active<=shadow at the same edge.
REQ-024 SHALL, on a write and a commit in the same RUN cycle, apply the write first so it is included in the commit.
REQ-025 SHALL ignore cfg_commit while in PENDING.
REQ-026 SHALL, with FRAME_LEN=1, treat every sample as a frame boundary and pulse frame_start on every update.
REQ-027 SHALL leave commit_pending asserted indefinitely while no samples arrive.

Reset
REQ-028 SHALL, on reset, set active and shadow maps to chan0=3'b000, chan1=3'b100, chan2=3'b010 (lines 0,1,2).
REQ-029 SHALL, on reset, clear outputs, out_strobe, frame_start, the counter and commit_pending, and enter RUN with cfg_ready=1.
REQ-030 SHALL, on reset mid-frame or while PENDING, discard the pending commit.

Configuration
REQ-031 SHALL, with DECOMM_COLLISION_FLAG_EN defined, add output port collision (1 bit): sticky, set at the first routed sample where two or more channels share a line, cleared only by rst.
REQ-032 SHALL, without DECOMM_COLLISION_FLAG_EN, omit the collision port and all its logic; routing priority is unchanged.

Structure
REQ-033 SHALL place the code-to-index decode function, the reset map constants and the FSM state typedef in a shared package decomm_pkg.
REQ-034 SHALL implement the map storage with write port and commit copy as one sub-module, decomm_map_reg; the router, counter and FSM SHALL live in the top module.

Verification
REQ-035 SHALL cover: reset, then in_valid with in_data=3'b101 -> next cycle outputs=8'b0000_0101, out_strobe=8'b0000_0111, frame_start=1.
REQ-036 SHALL cover: write chan2=3'b111, then commit at sample 3 with FRAME_LEN=8 -> samples 3..7 still use line 2; the sample after index 7 drives line 7; cfg_ready=0 in between.
REQ-037 SHALL cover: map chan0 and chan1 to 3'b001, in_data=3'b010 -> outputs[4]=0 (chan0 wins); collision=1 when enabled.
REQ-038 SHALL cover: write and commit in the same cycle, then 8 samples -> the new code is active from sample 8.
REQ-039 SHALL cover: rst asserted while PENDING -> commit_pending=0 immediately and the map returns to lines 0,1,2.
REQ-040 SHALL cover: FRAME_LEN=1 with commit -> the map switches after the next sample and frame_start=1 on every update.
